pair_list_scorer: RTL
=====================

Name: pair_list_scorer

Overview:
- Parametrised successor to the day-1 list collector/sorter/summer.
- Accepts a stream of (a, b) pairs over a valid/ready handshake and keeps two on-chip lists sorted as they arrive, using insertion sort on write.
- After the last pair, it walks both sorted lists and produces one score per job.
- Two modes: DISTANCE (sum of |a_i - b_i| over rank-matched elements) or SIMILARITY (sum over a_i of a_i * count of b equal to a_i).

Parameters:
- WIDTH, 32, bit width of each list element (unsigned).
- DEPTH, 1024, maximum pairs per job; must be >= 2.
- SUM_WIDTH, 64, width of the score accumulator and output.
- CNT_W, $clog2(DEPTH+1), width of the pair counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = DISTANCE, 1 = SIMILARITY; sampled on the beat carrying in_last.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_a  in  WIDTH  left-list element.
- in_b  in  WIDTH  right-list element.
- in_last  in  1  qualifies the final pair of a job; meaningful only when in_valid && in_ready.
- out_valid  out  1  score available.
- out_ready  in  1  consumer accepts the score.
- out_sum  out  SUM_WIDTH  job score.
- out_count  out  CNT_W  number of pairs actually stored.
- overflow  out  1  sticky per job: at least one pair was dropped.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high; also taken mid-job):
  - state goes to IDLE; stored count = 0.
  - in_ready = 0 during reset, 1 in the first cycle after release.
  - out_valid = 0, out_sum = 0, out_count = 0, overflow = 0, busy = 0.
  - List contents are don't-care and need not be cleared; any partial job is discarded.
- States: IDLE -> COLLECT -> SCORE -> HOLD -> IDLE.
- IDLE: in_ready = 1. An accepted beat inserts the pair, sets count = 1 and moves to COLLECT. If in_last is set on that beat, go straight to SCORE.
- COLLECT:
  - in_ready = 1; one insertion per accepted beat.
  - Each list inserts its element independently, in ascending order. Equal values go after existing equal values, so order is stable.
  - A new element is visible to the next insertion on the following cycle.
  - Beat accepted when count == DEPTH: pair discarded, overflow set, count unchanged. The handshake still completes.
  - Beat with in_last accepted: mode is latched and the state moves to SCORE. An in_last on a dropped overflow beat still ends the job.
- SCORE:
  - in_ready = 0; at most one element comparison per list per cycle.
  - DISTANCE: sum over i < count of |a[i] - b[i]|, each term computed as an unsigned WIDTH-bit difference.
  - SIMILARITY: merge walk with indices i, j over the sorted lists. Duplicate a values reuse the previous contribution; j never rewinds.
  - Accumulation is modulo 2^SUM_WIDTH (wraps, no saturation).
  - Latency from the in_last beat to out_valid is at most 2*count + 4 cycles, for either mode.
- HOLD:
  - out_valid = 1; out_sum, out_count and overflow are stable.
  - on out_valid && out_ready, the next cycle is IDLE with out_valid = 0 and overflow cleared. in_ready rises in that same cycle.
  - in_ready = 0 throughout HOLD, so no beat is accepted while the result waits.
- Simultaneous events: a reset asserted in the same cycle as an out handshake wins. The result is lost and out_valid drops.
- in_valid without in_ready is ignored; the producer must hold its data stable until accepted.

Decomposition:
- Package pair_list_pkg holds:
  - mode_t enum {MODE_DISTANCE, MODE_SIMILARITY};
  - state_t enum {IDLE, COLLECT, SCORE, HOLD};
  - an absolute-difference function.
- Sub-module sorted_insert_list (params WIDTH, DEPTH), instantiated twice:
  - register array with parallel compare-and-shift insertion;
  - read port indexed by position, returning the element the same cycle;
  - clear input.
- Top level holds the FSM, counters, merge walk, accumulator and output register.

Test Plan:
- a = 3,4,2,1,3,3; b = 4,3,5,3,9,3; mode 0, in_last on the 6th beat -> out_sum = 11, out_count = 6, overflow = 0. out_valid within 16 cycles of the in_last beat.
- Same data, mode 1 -> out_sum = 31; exercises duplicate a values (three 3s) and the no-rewind requirement.
- DEPTH = 4, send 6 pairs (1,1)(2,2)(3,3)(4,4)(9,0)(9,0), mode 0, in_last on the 6th -> out_count = 4, out_sum = 0, overflow = 1. After the out handshake, a new job reports overflow = 0.
- WIDTH = 8, SUM_WIDTH = 8, pairs (255,0) x 2, mode 0 -> out_sum = 254 (wraps, 510 mod 256).
- Hold out_ready = 0 for 10 cycles in HOLD -> out_valid, out_sum, out_count and overflow stay stable, and no input beat is accepted. Raise out_ready -> in the next cycle out_valid = 0 and in_ready = 1.
- Assert reset during COLLECT after 3 beats -> all outputs return to reset values. A following single-pair job (7,5), in_last, mode 0 -> out_sum = 2, out_count = 1.

Source files
------------

// File: rtl/pair_list_pkg.sv
// Shared types and helpers for the pair-list scorer.
// Holds the job modes, the FSM state encoding and the unsigned absolute-difference helper.
package pair_list_pkg;

    typedef enum logic {
        MODE_DISTANCE   = 1'b0,
        MODE_SIMILARITY = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SCORE   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Widest element the difference helper supports; callers zero-extend into it.
    localparam int ABS_MAX_W = 64;

    function automatic logic [ABS_MAX_W-1:0] abs_diff(input logic [ABS_MAX_W-1:0] x,
                                                      input logic [ABS_MAX_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/sorted_insert_list.sv
// Ascending register list with single-cycle compare-and-shift insertion and a same-cycle read port.
// Insert is visible one cycle later; inserts while full are ignored, so the caller must flag the drop.
module sorted_insert_list
    import pair_list_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             ins_vld,
    input  logic [WIDTH-1:0] ins_dat,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] nxt [DEPTH];
    logic [DEPTH-1:0] shift;
    logic             full;

    assign full   = (count == CNT_W'(DEPTH));
    assign rd_dat = mem[rd_idx];

    // Slots past the fill level count as "greater" so the shift mask stays a
    // contiguous run of ones; strict compare keeps equal values in arrival order.
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        assign shift[k] = (CNT_W'(k) >= count) || (mem[k] > ins_dat);
        if (k == 0) begin : g_head
            assign nxt[k] = ins_dat;
        end else begin : g_body
            assign nxt[k] = shift[k-1] ? mem[k-1] : ins_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (ins_vld && !full) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (shift[k]) begin
                    mem[k] <= nxt[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (ins_vld && !full) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pair_list_scorer.sv
// Collects (a, b) pairs into two sorted lists, then scores them by rank distance or value similarity.
// Result within 2*count+4 cycles of the last beat; input stalls from SCORE until the result is taken.
module pair_list_scorer
    import pair_list_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 1024,
    parameter int SUM_WIDTH = 64,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 overflow,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t               state;
    mode_t                mode_q;
    logic [CNT_W-1:0]     count_a;
    logic [CNT_W-1:0]     count_b;
    logic [CNT_W-1:0]     idx_i;
    logic [CNT_W-1:0]     idx_j;
    logic [CNT_W-1:0]     match_cnt;
    logic [WIDTH-1:0]     a_rd;
    logic [WIDTH-1:0]     b_rd;
    logic [WIDTH-1:0]     prev_val;
    logic                 prev_vld;
    logic [SUM_WIDTH-1:0] prev_contrib;
    logic [SUM_WIDTH-1:0] acc;
    logic [SUM_WIDTH-1:0] dist_term;
    logic [SUM_WIDTH-1:0] contrib;
    logic                 accept;
    logic                 full;
    logic                 clear;
    logic                 i_done;
    logic                 j_more;

    assign in_ready  = !reset && (state == IDLE || state == COLLECT);
    assign accept    = in_valid && in_ready;
    assign full      = (count_a == CNT_W'(DEPTH));
    assign clear     = (state == HOLD) && out_ready;
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_count = count_a;
    assign busy      = (state != IDLE);

    assign i_done    = (idx_i >= count_a);
    assign j_more    = (idx_j < count_b);
    // |a-b| of WIDTH-bit operands always fits WIDTH bits, so a plain resize is exact.
    assign dist_term = SUM_WIDTH'(abs_diff(ABS_MAX_W'(a_rd), ABS_MAX_W'(b_rd)));
    assign contrib   = SUM_WIDTH'(a_rd) * SUM_WIDTH'(match_cnt);

    sorted_insert_list #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_list_a (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .ins_vld (accept),
        .ins_dat (in_a),
        .rd_idx  (idx_i[IDX_W-1:0]),
        .rd_dat  (a_rd),
        .count   (count_a)
    );

    sorted_insert_list #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_list_b (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .ins_vld (accept),
        .ins_dat (in_b),
        .rd_idx  (idx_j[IDX_W-1:0]),
        .rd_dat  (b_rd),
        .count   (count_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mode_q       <= MODE_DISTANCE;
            overflow     <= 1'b0;
            acc          <= '0;
            idx_i        <= '0;
            idx_j        <= '0;
            match_cnt    <= '0;
            prev_val     <= '0;
            prev_vld     <= 1'b0;
            prev_contrib <= '0;
        end else begin
            case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (state == IDLE) begin
                            idx_i     <= '0;
                            idx_j     <= '0;
                            match_cnt <= '0;
                            prev_vld  <= 1'b0;
                        end
                        if (full) begin
                            overflow <= 1'b1;
                        end
                        if (in_last) begin
                            mode_q <= mode_t'(mode);
                            state  <= SCORE;
                        end else begin
                            state  <= COLLECT;
                        end
                    end
                end
                SCORE: begin
                    if (i_done) begin
                        state <= HOLD;
                    end else if (mode_q == MODE_DISTANCE) begin
                        acc   <= acc + dist_term;
                        idx_i <= idx_i + 1'b1;
                        idx_j <= idx_j + 1'b1;
                    end else if (prev_vld && a_rd == prev_val) begin
                        // Repeated a value: b run was already consumed, reuse its score.
                        acc   <= acc + prev_contrib;
                        idx_i <= idx_i + 1'b1;
                    end else if (j_more && b_rd < a_rd) begin
                        idx_j <= idx_j + 1'b1;
                    end else if (j_more && b_rd == a_rd) begin
                        match_cnt <= match_cnt + 1'b1;
                        idx_j     <= idx_j + 1'b1;
                    end else begin
                        acc          <= acc + contrib;
                        prev_contrib <= contrib;
                        prev_val     <= a_rd;
                        prev_vld     <= 1'b1;
                        match_cnt    <= '0;
                        idx_i        <= idx_i + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state    <= IDLE;
                        overflow <= 1'b0;
                        acc      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
